// File: rtl/cpu_subsys_mem_arbiter.sv
// cpu_subsys_mem_arbiter
// Round-robin arbiter that lets the CPU instruction port (m0) and data port
// (m1) share one valid/ready memory target, one transaction in flight.
//
// Ports:
//   sys_clk, rst_n            clock, asynchronous active-low reset
//   mN_req/addr/we/be/wdata   requester command (N = 0 instr, 1 data)
//   mN_gnt                    combinational grant, single cycle
//   mN_rvalid/rdata/err       registered one-cycle response
//   mem_valid/addr/wdata/wstrb registered target command (wstrb 0 = read)
//   mem_ready/rdata           target completion pulse and read data
//
// Build option: define CPU_SUBSYS_MEM_ARB_TIMEOUT_EN to add a watchdog that
// aborts a transaction after TIMEOUT_CYCLES cycles without mem_ready and
// answers with err=1, rdata=32'hDEAD_BEEF. TIMEOUT_CYCLES exists only in
// that build (legal range 2..65535).
module cpu_subsys_mem_arbiter
`ifdef CPU_SUBSYS_MEM_ARB_TIMEOUT_EN
  #(parameter int unsigned TIMEOUT_CYCLES = 256)
`endif
(
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        m0_req,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic        m0_err,
  input  logic [31:0] m0_addr,
  input  logic        m0_we,
  input  logic [3:0]  m0_be,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic        m1_err,
  input  logic [31:0] m1_addr,
  input  logic        m1_we,
  input  logic [3:0]  m1_be,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // Command held toward the target for the whole BUSY phase.
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
  } mem_cmd_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_grant_q, last_grant_d;
  logic          mem_valid_q, mem_valid_d;
  mem_cmd_t      cmd_q, cmd_d;
  logic [DW-1:0] m0_rdata_q, m0_rdata_d;
  logic [DW-1:0] m1_rdata_q, m1_rdata_d;
  logic [1:0]    rvalid_q, rvalid_d;
  logic [1:0]    gnt_c;
  logic          win;

`ifdef CPU_SUBSYS_MEM_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       err_q, err_d;
`endif

  // State and datapath registers.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      mem_valid_q  <= 1'b0;
      cmd_q        <= '0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
      rvalid_q     <= 2'b00;
`ifdef CPU_SUBSYS_MEM_ARB_TIMEOUT_EN
      cnt_q        <= '0;
      err_q        <= 2'b00;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      mem_valid_q  <= mem_valid_d;
      cmd_q        <= cmd_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
      rvalid_q     <= rvalid_d;
`ifdef CPU_SUBSYS_MEM_ARB_TIMEOUT_EN
      cnt_q        <= cnt_d;
      err_q        <= err_d;
`endif
    end
  end

  // Next-state, arbitration and response selection.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    mem_valid_d  = mem_valid_q;
    cmd_d        = cmd_q;
    m0_rdata_d   = m0_rdata_q;
    m1_rdata_d   = m1_rdata_q;
    rvalid_d     = 2'b00;
    gnt_c        = 2'b00;
    win          = 1'b0;
`ifdef CPU_SUBSYS_MEM_ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
    err_d        = 2'b00;
`endif

    unique case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          // A tie goes to the port that did not win last time.
          win          = (m0_req && m1_req) ? ~last_grant_q : m1_req;
          gnt_c        = win ? 2'b10 : 2'b01;
          owner_d      = win;
          last_grant_d = win;
          cmd_d.addr   = win ? m1_addr : m0_addr;
          cmd_d.wdata  = win ? m1_wdata : m0_wdata;
          if (win) begin
            cmd_d.wstrb = m1_we ? m1_be : SW'(0);
          end else begin
            cmd_d.wstrb = m0_we ? m0_be : SW'(0);
          end
          mem_valid_d  = 1'b1;
          state_d      = BUSY;
`ifdef CPU_SUBSYS_MEM_ARB_TIMEOUT_EN
          cnt_d        = '0;
`endif
        end
      end

      BUSY: begin
        // Completion wins over a watchdog expiry in the same cycle.
        if (mem_ready) begin
          if (owner_q) begin
            m1_rdata_d = mem_rdata;
          end else begin
            m0_rdata_d = mem_rdata;
          end
          rvalid_d    = owner_q ? 2'b10 : 2'b01;
          mem_valid_d = 1'b0;
          state_d     = RESP;
        end
`ifdef CPU_SUBSYS_MEM_ARB_TIMEOUT_EN
        else if (cnt_q == TMO_LAST) begin
          if (owner_q) begin
            m1_rdata_d = 32'hDEAD_BEEF;
          end else begin
            m0_rdata_d = 32'hDEAD_BEEF;
          end
          rvalid_d    = owner_q ? 2'b10 : 2'b01;
          err_d       = owner_q ? 2'b10 : 2'b01;
          mem_valid_d = 1'b0;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end

      RESP: begin
        // rvalid is high for this single cycle; no grant is issued here.
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign m0_gnt    = gnt_c[0];
  assign m1_gnt    = gnt_c[1];
  assign m0_rvalid = rvalid_q[0];
  assign m1_rvalid = rvalid_q[1];
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;
  assign mem_valid = mem_valid_q;
  assign mem_addr  = cmd_q.addr;
  assign mem_wdata = cmd_q.wdata;
  assign mem_wstrb = cmd_q.wstrb;

`ifdef CPU_SUBSYS_MEM_ARB_TIMEOUT_EN
  assign m0_err = err_q[0];
  assign m1_err = err_q[1];
`else
  assign m0_err = 1'b0;
  assign m1_err = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_subsys_mem_arbiter.sv
// Bench for cpu_subsys_mem_arbiter: directed scenarios followed by random
// traffic, checked each cycle against a transaction-level timeline model
// (grant cycle, completion cycle, response cycle) and a word memory that
// plays the target.
module tb_cpu_subsys_mem_arbiter;

`ifdef CPU_SUBSYS_MEM_ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif
  localparam int TMO   = 8;
  localparam int NEVER = 32'h3fff_ffff;

  logic        sys_clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m1_req, m0_gnt, m1_gnt;
  logic        m0_rvalid, m1_rvalid, m0_err, m1_err;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata, m0_rdata, m1_rdata;
  logic        m0_we, m1_we;
  logic [3:0]  m0_be, m1_be;
  logic        mem_valid, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  always #5 sys_clk = ~sys_clk;

`ifdef CPU_SUBSYS_MEM_ARB_TIMEOUT_EN
  cpu_subsys_mem_arbiter #(.TIMEOUT_CYCLES(TMO)) u_dut (
`else
  cpu_subsys_mem_arbiter u_dut (
`endif
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .m0_req    (m0_req),
    .m0_gnt    (m0_gnt),
    .m0_rvalid (m0_rvalid),
    .m0_err    (m0_err),
    .m0_addr   (m0_addr),
    .m0_we     (m0_we),
    .m0_be     (m0_be),
    .m0_wdata  (m0_wdata),
    .m0_rdata  (m0_rdata),
    .m1_req    (m1_req),
    .m1_gnt    (m1_gnt),
    .m1_rvalid (m1_rvalid),
    .m1_err    (m1_err),
    .m1_addr   (m1_addr),
    .m1_we     (m1_we),
    .m1_be     (m1_be),
    .m1_wdata  (m1_wdata),
    .m1_rdata  (m1_rdata),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Timeline model of the single transaction in flight.
  bit          pend;
  int          owner, gnt_cyc, done_cyc, free_cyc, last_win;
  bit          tmo_hit;
  logic [31:0] cap_addr, cap_wdata, resp_data;
  logic [3:0]  cap_wstrb;
  logic [31:0] exp_rdata [2];
  logic [31:0] mem [16];

  // Requester / target stimulus for the next cycle.
  bit          st_req [2];
  logic [31:0] st_addr [2];
  logic [31:0] st_wdata [2];
  bit          st_we [2];
  logic [3:0]  st_be [2];
  int          st_k;
  bit          st_stray;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic check_reset_values();
    check_eq("rst_mem_valid", 32'(mem_valid), 32'd0);
    check_eq("rst_mem_addr",  mem_addr, 32'd0);
    check_eq("rst_mem_wdata", mem_wdata, 32'd0);
    check_eq("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    check_eq("rst_m0_rvalid", 32'(m0_rvalid), 32'd0);
    check_eq("rst_m1_rvalid", 32'(m1_rvalid), 32'd0);
    check_eq("rst_m0_err",    32'(m0_err), 32'd0);
    check_eq("rst_m1_err",    32'(m1_err), 32'd0);
    check_eq("rst_m0_rdata",  m0_rdata, 32'd0);
    check_eq("rst_m1_rdata",  m1_rdata, 32'd0);
    check_eq("rst_m0_gnt",    32'(m0_gnt), 32'd0);
    check_eq("rst_m1_gnt",    32'(m1_gnt), 32'd0);
  endtask

  task automatic model_reset();
    pend      = 1'b0;
    last_win  = 1;
    free_cyc  = 0;
    exp_rdata = '{default: 32'd0};
  endtask

  // One clock cycle: drive at posedge+1, predict and compare at negedge.
  task automatic step();
    int         w;
    logic [1:0] e_gnt, e_rv, e_err;
    bit         e_valid;
    @(posedge sys_clk);
    #1;
    cyc++;
    m0_req = st_req[0];     m1_req = st_req[1];
    m0_addr = st_addr[0];   m1_addr = st_addr[1];
    m0_wdata = st_wdata[0]; m1_wdata = st_wdata[1];
    m0_we = st_we[0];       m1_we = st_we[1];
    m0_be = st_be[0];       m1_be = st_be[1];
    if (pend && !tmo_hit && cyc == done_cyc) begin
      mem_ready = 1'b1;
      if (cap_wstrb == 4'b0000) begin
        mem_rdata = mem[cap_addr[5:2]];
      end else begin
        mem_rdata = $urandom;
        for (int b = 0; b < 4; b++)
          if (cap_wstrb[b]) mem[cap_addr[5:2]][8*b +: 8] = cap_wdata[8*b +: 8];
      end
      resp_data = mem_rdata;
    end else begin
      mem_ready = st_stray && !(pend && cyc > gnt_cyc && cyc <= done_cyc);
      mem_rdata = $urandom;
    end

    @(negedge sys_clk);
    e_rv  = 2'b00;
    e_err = 2'b00;
    if (pend && cyc == done_cyc + 1) begin
      exp_rdata[owner] = tmo_hit ? 32'hDEAD_BEEF : resp_data;
      e_rv[owner]  = 1'b1;
      e_err[owner] = tmo_hit;
      pend     = 1'b0;
      free_cyc = cyc + 1;
    end
    e_gnt = 2'b00;
    if (!pend && cyc >= free_cyc && (st_req[0] || st_req[1])) begin
      w = (st_req[0] && st_req[1]) ? 1 - last_win : (st_req[1] ? 1 : 0);
      e_gnt[w]  = 1'b1;
      last_win  = w;
      pend      = 1'b1;
      owner     = w;
      gnt_cyc   = cyc;
      cap_addr  = st_addr[w];
      cap_wdata = st_wdata[w];
      cap_wstrb = st_we[w] ? st_be[w] : 4'b0000;
      if (st_k > 0 && (!TMO_EN || st_k <= TMO)) begin
        done_cyc = cyc + st_k;
        tmo_hit  = 1'b0;
      end else if (TMO_EN) begin
        done_cyc = cyc + TMO;
        tmo_hit  = 1'b1;
      end else begin
        done_cyc = NEVER;
        tmo_hit  = 1'b0;
      end
    end
    e_valid = pend && cyc > gnt_cyc && cyc <= done_cyc;

    check_eq("m0_gnt", 32'(m0_gnt), 32'(e_gnt[0]));
    check_eq("m1_gnt", 32'(m1_gnt), 32'(e_gnt[1]));
    check_eq("mem_valid", 32'(mem_valid), 32'(e_valid));
    if (e_valid) begin
      check_eq("mem_addr",  mem_addr, cap_addr);
      check_eq("mem_wdata", mem_wdata, cap_wdata);
      check_eq("mem_wstrb", 32'(mem_wstrb), 32'(cap_wstrb));
    end
    check_eq("m0_rvalid", 32'(m0_rvalid), 32'(e_rv[0]));
    check_eq("m1_rvalid", 32'(m1_rvalid), 32'(e_rv[1]));
    check_eq("m0_err",    32'(m0_err), 32'(e_err[0]));
    check_eq("m1_err",    32'(m1_err), 32'(e_err[1]));
    check_eq("m0_rdata",  m0_rdata, exp_rdata[0]);
    check_eq("m1_rdata",  m1_rdata, exp_rdata[1]);
  endtask

  // Assert reset in the middle of a cycle while a transaction is pending.
  task automatic reset_mid();
    @(posedge sys_clk);
    #1;
    rst_n  = 1'b0;
    m0_req = 1'b0;
    m1_req = 1'b0;
    mem_ready = 1'b0;
    st_req   = '{1'b0, 1'b0};
    st_stray = 1'b0;
    #1;
    check_eq("rst_async_mem_valid", 32'(mem_valid), 32'd0);
    @(negedge sys_clk);
    check_reset_values();
    @(negedge sys_clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic idle_reqs();
    st_req = '{1'b0, 1'b0};
  endtask

  initial begin
    rst_n = 1'b0;
    m0_req = 1'b0; m1_req = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
    m0_we = 1'b0; m1_we = 1'b0; m0_be = '0; m1_be = '0;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    for (int p = 0; p < 2; p++) begin
      st_req[p] = 1'b0; st_addr[p] = '0; st_wdata[p] = '0; st_we[p] = 1'b0; st_be[p] = '0;
    end
    st_k = 1; st_stray = 1'b0; tmo_hit = 1'b0;
    owner = 0; gnt_cyc = 0; done_cyc = 0;
    cap_addr = '0; cap_wdata = '0; cap_wstrb = '0; resp_data = '0;
    model_reset();

    repeat (3) @(negedge sys_clk);
    check_reset_values();
    rst_n = 1'b1;

    // m0 read of 0x10, zero-wait target.
    mem[4] = 32'h1234_5678;
    st_req[0] = 1'b1; st_addr[0] = 32'h0000_0010; st_we[0] = 1'b0; st_k = 1;
    step();
    st_req[0] = 1'b0; st_addr[0] = $urandom;
    repeat (3) step();
    check_eq("t1_m0_rdata", m0_rdata, 32'h1234_5678);

    // Both ports requesting continuously: grants alternate.
    st_req = '{1'b1, 1'b1}; st_k = 1;
    st_addr[0] = 32'h0000_0020; st_addr[1] = 32'h0000_0024;
    repeat (12) step();
    idle_reqs();
    repeat (3) step();

    // m1 byte-lane write with a 5-cycle target; inputs change after grant.
    st_req[1] = 1'b1; st_we[1] = 1'b1; st_be[1] = 4'b0110;
    st_wdata[1] = 32'hAABB_CCDD; st_addr[1] = 32'h2000_0004; st_k = 5;
    step();
    st_req[1] = 1'b0; st_addr[1] = $urandom; st_wdata[1] = $urandom; st_be[1] = 4'hF;
    repeat (7) step();
    st_we[1] = 1'b0;

    // Stray ready pulses while idle and in the response cycle are ignored.
    st_stray = 1'b1;
    repeat (3) step();
    st_req[0] = 1'b1; st_addr[0] = 32'h0000_0030; st_k = 3;
    step();
    st_req[0] = 1'b0;
    repeat (6) step();
    st_stray = 1'b0;

    // Reset during BUSY; afterwards the first tie goes to m0 again.
    st_req[1] = 1'b1; st_addr[1] = 32'h0000_0008; st_k = 6;
    step();
    st_req[1] = 1'b0;
    repeat (2) step();
    reset_mid();
    st_req = '{1'b1, 1'b1}; st_k = 1;
    step();
    check_eq("t5_tie_after_rst", 32'(m0_gnt), 32'd1);
    idle_reqs();
    repeat (3) step();

    // Target never readies.
    st_req[0] = 1'b1; st_addr[0] = 32'h0000_0004; st_k = 0;
    step();
    st_req[0] = 1'b0;
    repeat (TMO + 3) step();
`ifdef CPU_SUBSYS_MEM_ARB_TIMEOUT_EN
    check_eq("t6_tmo_rdata", m0_rdata, 32'hDEAD_BEEF);
`else
    repeat (10) step();
    reset_mid();
`endif

    // Ready on the expiry cycle completes normally.
    st_req[0] = 1'b1; st_addr[0] = 32'h0000_000C; st_k = TMO;
    step();
    st_req[0] = 1'b0;
    repeat (TMO + 3) step();

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      for (int p = 0; p < 2; p++) begin
        st_req[p]   = ($urandom_range(0, 1) == 1);
        st_addr[p]  = $urandom;
        st_wdata[p] = $urandom;
        st_we[p]    = ($urandom_range(0, 1) == 1);
        st_be[p]    = 4'($urandom);
      end
      st_k     = $urandom_range(1, 4);
      st_stray = ($urandom_range(0, 3) == 0);
      step();
    end
    idle_reqs();
    st_stray = 1'b0;
    repeat (6) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_subsys_mem_arbiter.md
# cpu_subsys_mem_arbiter

Two-requester arbiter that shares one valid/ready memory port (ROM, SRAM or peripheral bus) between the CPU instruction-fetch port and data port, both of which use req/gnt/rvalid handshakes. It sits between the CPU core and a shared memory target so that a single memory instance can serve both code and data. Arbitration is round-robin with one outstanding transaction at a time. An optional watchdog aborts transactions the target never completes.

## Interface
- TIMEOUT_CYCLES, 256: cycles `mem_valid` may stay high without `mem_ready` before an abort (watchdog build only); legal range 2..65535.
- sys_clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- m0_req, m1_req  in  1  request; port 0 = instruction, port 1 = data.
- m0_gnt, m1_gnt  out  1  grant; combinational, one cycle.
- m0_rvalid, m1_rvalid  out  1  response valid; one-cycle pulse.
- m0_err, m1_err  out  1  response error, valid with rvalid.
- m0_addr, m1_addr  in  32  byte address.
- m0_we, m1_we  in  1  write enable.
- m0_be, m1_be  in  4  byte enables.
- m0_wdata, m1_wdata  in  32  write data.
- m0_rdata, m1_rdata  out  32  read data, valid with rvalid.
- mem_valid  out  1  target request; registered.
- mem_ready  in  1  target completion; one-cycle pulse.
- mem_addr  out  32  registered address.
- mem_wdata  out  32  registered write data.
- mem_wstrb  out  4  registered strobes; 4'b0000 means read.
- mem_rdata  in  32  target read data, sampled when mem_ready=1.

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If either req is high, select the winner. Only one requesting: it wins. Both requesting: the port not in `last_grant` wins.
  - Assert the winner's gnt combinationally in the same cycle. The loser's gnt stays 0.
  - On the clock edge, latch `owner` and update `last_grant` to the winner.
  - Also latch mem_addr=addr and mem_wdata=wdata.
  - Latch mem_wstrb = we ? be : 4'b0000.
  - Set mem_valid=1 and go to BUSY.
- BUSY:
  - Hold mem_valid and mem_addr/wdata/wstrb stable. gnt outputs are 0.
  - On mem_ready=1: register mem_rdata into the owner's rdata (for writes too, value don't-care), clear err, clear mem_valid, go to RESP.
- RESP:
  - Owner's rvalid=1 for exactly one cycle, then return to IDLE.
  - No grant is issued in RESP, so back-to-back transactions are spaced by one idle cycle.
- Non-owner rvalid/err are always 0. m0_rdata/m1_rdata hold their last value until overwritten.
- mem_ready while mem_valid=0 (IDLE/RESP) is ignored.
- Requester address/data are not sampled after gnt; requesters may change them freely.
- Reset values: state=IDLE, last_grant=1 (port 0 wins first tie), mem_valid=0, mem_addr/mem_wdata=0, mem_wstrb=0, all rvalid/err=0, m0/m1_rdata=0.
- Reset asserted mid-transaction: mem_valid drops immediately (asynchronously), the pending response is discarded, and no rvalid is produced after release.

## Timing
- Cycle N: req and gnt high.
- Cycle N+1: mem_valid=1.
- If mem_ready is high in cycle N+k (k≥1), mem_valid=0 and rvalid=1 in cycle N+k+1.
- The earliest next gnt is cycle N+k+2.
- Zero-wait target (ready in N+1): rvalid in N+2; throughput is one transaction per 3 cycles.

## Configuration
- Macro `CPU_SUBSYS_MEM_ARB_TIMEOUT_EN`.
- Defined:
  - A 16-bit counter clears on entry to BUSY and increments each BUSY cycle without mem_ready.
  - When the count reaches TIMEOUT_CYCLES-1 without ready, the arbiter clears mem_valid and goes to RESP.
  - The owner then gets rvalid=1, err=1 and rdata=32'hDEAD_BEEF.
  - mem_ready in the same cycle as expiry takes priority: normal completion, err=0.
- Undefined: no counter; m0_err/m1_err are tied to 0; BUSY waits indefinitely.

## Test plan
- Reset release, then m0 reads addr 0x0000_0010 with the target returning 0x1234_5678 on ready at k=1 -> m0_gnt in cycle 0, mem_valid in cycle 1, m0_rvalid with rdata=0x1234_5678 in cycle 2, m1 outputs quiet.
- m0 and m1 request simultaneously and hold requests continuously -> grants alternate m0, m1, m0, m1 with gnt edges 3 cycles apart at k=1.
- m1 writes we=1, be=4'b0110, wdata=0xAABB_CCDD to 0x2000_0004 with k=5 -> mem_wstrb=4'b0110 and data held stable for 5 cycles, m1_rvalid 1 cycle after ready, err=0.
- m0 read with the target issuing ready in cycle 3, plus a stray mem_ready pulse during IDLE -> the stray pulse produces no rvalid and no state change.
- rst_n asserted in BUSY (k pending) -> mem_valid=0 in the same cycle, no rvalid after release, the next request gets gnt normally.
- With CPU_SUBSYS_MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, the target never readies -> mem_valid high for 8 cycles, then m0_rvalid=1, m0_err=1, rdata=0xDEAD_BEEF. Without the macro, mem_valid stays high indefinitely and err stays 0.
